// File: rtl/demux_serializer.sv
// demux_serializer: accepts a handshaked (sel, payload) frame and shifts the payload out LSB-first to a demux tree
module demux_serializer #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [SEL_W-1:0]  s_sel,
  input  logic [DATA_W-1:0] s_data,
  output logic              dmx_in,
  output logic [SEL_W-1:0]  dmx_sel,
  output logic              dmx_en,
  output logic              busy,
  output logic              done
);
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t            state;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] sh_nx;
  logic [CW-1:0]     cnt;
  logic              last;
  always_comb begin
    sh_nx   = sh >> 1;
    last    = cnt == CW'(DATA_W - 1);
    s_ready = state == IDLE;
  end
  // dmx_in is registered one step ahead so it always equals the current shift_reg[0]
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      sh      <= '0;
      cnt     <= '0;
      dmx_sel <= '0;
      dmx_in  <= 1'b0;
      dmx_en  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (s_valid) begin
          state   <= SHIFT;
          sh      <= s_data;
          dmx_sel <= s_sel;
          cnt     <= '0;
          dmx_in  <= s_data[0];
          dmx_en  <= 1'b1;
          busy    <= 1'b1;
        end
        SHIFT: begin
          sh     <= sh_nx;
          cnt    <= cnt + 1'b1;
          state  <= last ? DONE : SHIFT;
          dmx_in <= last ? 1'b0 : sh_nx[0];
          dmx_en <= !last;
          done   <= last;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          dmx_en <= 1'b0;
          dmx_in <= 1'b0;
          done   <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_demux_serializer.sv
// tb_demux_serializer: directed self-checking bench for demux_serializer (DATA_W=8 and DATA_W=1 instances)
module tb_demux_serializer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0, s_ready;
  logic [2:0] s_sel = '0, dmx_sel;
  logic [7:0] s_data = '0;
  logic       dmx_in, dmx_en, busy, done;
  logic       v1 = 1'b0, rdy1, in1, en1, busy1, done1;
  logic [2:0] sel1 = '0, dsel1;
  logic [0:0] d1 = '0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  demux_serializer #(.DATA_W(8), .SEL_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_sel(s_sel),
    .s_data(s_data), .dmx_in(dmx_in), .dmx_sel(dmx_sel), .dmx_en(dmx_en), .busy(busy), .done(done)
  );

  demux_serializer #(.DATA_W(1), .SEL_W(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .s_valid(v1), .s_ready(rdy1), .s_sel(sel1),
    .s_data(d1), .dmx_in(in1), .dmx_sel(dsel1), .dmx_en(en1), .busy(busy1), .done(done1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if ({dmx_en, dmx_in, busy, done, dmx_sel} !== 7'd0) begin failures++; $display("FAIL reset_during got=%b exp=0000000", {dmx_en, dmx_in, busy, done, dmx_sel}); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if ({s_ready, busy, dmx_en, dmx_in, done, dmx_sel} !== 8'b1000_0000) begin failures++; $display("FAIL reset_idle cyc=%0d got=%b exp=10000000", i, {s_ready, busy, dmx_en, dmx_in, done, dmx_sel}); end
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp = 8'b1011_0010;
    s_valid = 1'b1; s_sel = 3'd5; s_data = exp;
    tick();
    s_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if ({dmx_en, dmx_in, dmx_sel, s_ready, busy, done} !== {1'b1, exp[i], 3'd5, 1'b0, 1'b1, 1'b0}) begin failures++; $display("FAIL basic_bit%0d got=%b exp=%b", i, {dmx_en, dmx_in, dmx_sel, s_ready, busy, done}, {1'b1, exp[i], 3'd5, 3'b010}); end
      tick();
    end
    checks++; if ({done, dmx_en, dmx_in, s_ready, busy} !== 5'b10001) begin failures++; $display("FAIL basic_done got=%b exp=10001", {done, dmx_en, dmx_in, s_ready, busy}); end
    tick();
    checks++; if ({s_ready, busy, done, dmx_sel} !== {3'b100, 3'd5}) begin failures++; $display("FAIL basic_ready got=%b exp=100101", {s_ready, busy, done, dmx_sel}); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp2 = 8'h01;
    s_valid = 1'b1; s_sel = 3'd2; s_data = 8'hFF;
    tick();
    s_sel = 3'd7; s_data = exp2;
    for (int i = 0; i < 8; i++) begin
      checks++; if ({dmx_en, dmx_in, dmx_sel} !== {2'b11, 3'd2}) begin failures++; $display("FAIL b2b_first_bit%0d got=%b exp=11010", i, {dmx_en, dmx_in, dmx_sel}); end
      tick();
    end
    checks++; if ({done, dmx_sel} !== {1'b1, 3'd2}) begin failures++; $display("FAIL b2b_done got=%b exp=1010", {done, dmx_sel}); end
    tick();
    checks++; if ({s_ready, dmx_sel, dmx_en} !== {1'b1, 3'd2, 1'b0}) begin failures++; $display("FAIL b2b_gap got=%b exp=10100", {s_ready, dmx_sel, dmx_en}); end
    tick();
    s_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if ({dmx_en, dmx_in, dmx_sel} !== {1'b1, exp2[i], 3'd7}) begin failures++; $display("FAIL b2b_second_bit%0d got=%b exp=%b", i, {dmx_en, dmx_in, dmx_sel}, {1'b1, exp2[i], 3'd7}); end
      tick();
    end
    tick();
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL b2b_end got=%b exp=1", s_ready); end
  endtask

  task automatic test_midframe_change();
    logic [7:0] exp = 8'hA5;
    s_valid = 1'b1; s_sel = 3'd1; s_data = exp;
    tick();
    s_sel = 3'd6; s_data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      checks++; if ({dmx_en, dmx_in, dmx_sel, s_ready} !== {1'b1, exp[i], 3'd1, 1'b0}) begin failures++; $display("FAIL mid_bit%0d got=%b exp=%b", i, {dmx_en, dmx_in, dmx_sel, s_ready}, {1'b1, exp[i], 3'd1, 1'b0}); end
      tick();
    end
    checks++; if ({done, dmx_sel} !== {1'b1, 3'd1}) begin failures++; $display("FAIL mid_done got=%b exp=1001", {done, dmx_sel}); end
    tick();
    checks++; if ({s_ready, dmx_sel} !== {1'b1, 3'd1}) begin failures++; $display("FAIL mid_ready got=%b exp=1001", {s_ready, dmx_sel}); end
    tick();
    s_valid = 1'b0;
    checks++; if ({dmx_en, dmx_in, dmx_sel, busy} !== {2'b10, 3'd6, 1'b1}) begin failures++; $display("FAIL mid_second_accept got=%b exp=101101", {dmx_en, dmx_in, dmx_sel, busy}); end
    for (int i = 0; i < 9; i++) tick();
    checks++; if ({s_ready, busy} !== 2'b10) begin failures++; $display("FAIL mid_end got=%b exp=10", {s_ready, busy}); end
  endtask

  task automatic test_reset_abort();
    logic [7:0] exp = 8'hC3;
    logic [7:0] exp2 = 8'h3C;
    int dones = 0;
    s_valid = 1'b1; s_sel = 3'd4; s_data = exp;
    tick();
    s_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if ({dmx_en, dmx_in, dmx_sel} !== {1'b1, exp[i], 3'd4}) begin failures++; $display("FAIL abort_bit%0d got=%b exp=%b", i, {dmx_en, dmx_in, dmx_sel}, {1'b1, exp[i], 3'd4}); end
      if (i < 3) tick();
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({dmx_en, dmx_in, busy, done, dmx_sel} !== 7'd0) begin failures++; $display("FAIL abort_async got=%b exp=0000000", {dmx_en, dmx_in, busy, done, dmx_sel}); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) dones++;
      tick();
    end
    checks++; if (dones !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
    checks++; if ({s_ready, busy} !== 2'b10) begin failures++; $display("FAIL abort_ready got=%b exp=10", {s_ready, busy}); end
    s_valid = 1'b1; s_sel = 3'd3; s_data = exp2;
    tick();
    s_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if ({dmx_en, dmx_in, dmx_sel} !== {1'b1, exp2[i], 3'd3}) begin failures++; $display("FAIL abort_new_bit%0d got=%b exp=%b", i, {dmx_en, dmx_in, dmx_sel}, {1'b1, exp2[i], 3'd3}); end
      tick();
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL abort_new_done got=%b exp=1", done); end
    tick();
  endtask

  task automatic test_width1();
    v1 = 1'b1; sel1 = 3'd0; d1 = 1'b1;
    tick();
    v1 = 1'b0;
    checks++; if ({en1, in1, rdy1, busy1, done1, dsel1} !== {5'b11010, 3'd0}) begin failures++; $display("FAIL w1_bit got=%b exp=11010000", {en1, in1, rdy1, busy1, done1, dsel1}); end
    tick();
    checks++; if ({en1, in1, rdy1, busy1, done1} !== 5'b00011) begin failures++; $display("FAIL w1_done got=%b exp=00011", {en1, in1, rdy1, busy1, done1}); end
    tick();
    checks++; if ({en1, rdy1, busy1, done1} !== 4'b0100) begin failures++; $display("FAIL w1_ready got=%b exp=0100", {en1, rdy1, busy1, done1}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_midframe_change();
    test_reset_abort();
    test_width1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
